// File: rtl/pixel_pll_supervisor.sv
// Pixel-clock PLL supervisor: PLL reset sequencing, lock qualification, retry and mode selection.
// Optional feature macro: PLL_SUP_AUTO_RELOCK_EN (lock loss in RUN restarts the PLL instead of faulting).
//
// state       | meaning
// RESET_PLL   | PLL held in reset for RST_CYCLES
// WAIT_LOCK   | waiting for synchronised lock, timeout armed
// STABLE      | counting consecutive lock cycles
// RUN         | clock trusted, pixel domain released
// FAULT       | lock never obtained (or lost), sticky
module pixel_pll_supervisor #(
    parameter int NUM_MODES           = 2,
    parameter int DEFAULT_MODE        = 1,
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRIES         = 3,
    parameter int MODE_W  = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1,
    parameter int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    input  logic [MODE_W-1:0]  mode_sel,
    input  logic               mode_req,
    output logic               pll_rst,
    output logic [MODE_W-1:0]  pll_mode,
    output logic               pixel_rst,
    output logic               ready,
    output logic               fault,
    output logic               mode_err,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ? CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   RST_LOAD  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STB_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TMO_LOAD  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [MODE_W:0]    MODES_LIM = (MODE_W + 1)'(NUM_MODES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic [MODE_W-1:0]  mode_nxt;
    logic               lock_meta, lock_s;
    logic               mode_ok;

    assign mode_ok = mode_req && ({1'b0, mode_sel} < MODES_LIM);

    function automatic logic [CNT_W-1:0] load_for(state_t s);
        case (s)
            S_RESET_PLL: return RST_LOAD;
            S_WAIT_LOCK: return TMO_LOAD;
            S_STABLE:    return STB_LOAD;
            default:     return '0;
        endcase
    endfunction

    // Synchroniser is flushed while the PLL is in reset so stale lock is never trusted.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else if (pll_rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= locked;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_count;
        mode_nxt  = pll_mode;
        cnt_nxt   = cnt;
        if (mode_ok) begin
            mode_nxt  = mode_sel;
            retry_nxt = '0;
            state_nxt = S_RESET_PLL;
        end else begin
            case (state)
                S_RESET_PLL: if (cnt == '0) state_nxt = S_WAIT_LOCK;
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                    end else if (cnt == '0) begin
                        if (retry_count < RETRY_MAX) begin
                            retry_nxt = retry_count + RETRY_W'(1);
                            state_nxt = S_RESET_PLL;
                        end else begin
                            state_nxt = S_FAULT;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_s)          state_nxt = S_WAIT_LOCK;
                    else if (cnt == '0)   state_nxt = S_RUN;
                end
                S_RUN: begin
                    if (!lock_s) begin
`ifdef PLL_SUP_AUTO_RELOCK_EN
                        state_nxt = S_RESET_PLL;
                        retry_nxt = '0;
`else
                        state_nxt = S_FAULT;
`endif
                    end
                end
                S_FAULT: state_nxt = S_FAULT;
                default: state_nxt = S_RESET_PLL;
            endcase
        end
        // Every entry (including re-entry on an accepted request) reloads the down-counter.
        if (mode_ok || (state_nxt != state)) cnt_nxt = load_for(state_nxt);
        else if (cnt != '0)                  cnt_nxt = cnt - CNT_W'(1);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state       <= S_RESET_PLL;
            cnt         <= RST_LOAD;
            retry_count <= '0;
            pll_mode    <= MODE_W'(DEFAULT_MODE);
            pll_rst     <= 1'b1;
            pixel_rst   <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
            mode_err    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_count <= retry_nxt;
            pll_mode    <= mode_nxt;
            pll_rst     <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
            pixel_rst   <= (state_nxt != S_RUN);
            ready       <= (state_nxt == S_RUN);
            fault       <= (state_nxt == S_FAULT);
            mode_err    <= mode_req && !mode_ok;
        end
    end

endmodule

// File: tb/tb_pixel_pll_supervisor.sv
// Randomised and directed bench for pixel_pll_supervisor against a phase/elapsed-time reference model.
module tb_pixel_pll_supervisor;

    localparam int RST_C  = 4;
    localparam int STAB_C = 8;
    localparam int TMO_C  = 32;
    localparam int MAXR   = 2;
    localparam int NMODES = 2;

    localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FLT = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b1;
    logic       mode_sel = 1'b0;
    logic       mode_req = 1'b0;
    logic       pll_rst, pll_mode, pixel_rst, ready, fault, mode_err;
    logic [1:0] retry_count;

    logic [1:0] mode_sel3 = 2'd0;
    logic       mode_req3 = 1'b0;
    logic       pll_rst3, pixel_rst3, ready3, fault3, mode_err3;
    logic [1:0] pll_mode3, retry_count3;

    int n_tests = 0;
    int n_fail  = 0;

    pixel_pll_supervisor #(
        .NUM_MODES(NMODES), .DEFAULT_MODE(1), .RST_CYCLES(RST_C),
        .LOCK_STABLE_CYCLES(STAB_C), .LOCK_TIMEOUT_CYCLES(TMO_C), .MAX_RETRIES(MAXR)
    ) u_dut (
        .refclk(refclk), .rst(rst), .locked(locked), .mode_sel(mode_sel), .mode_req(mode_req),
        .pll_rst(pll_rst), .pll_mode(pll_mode), .pixel_rst(pixel_rst), .ready(ready),
        .fault(fault), .mode_err(mode_err), .retry_count(retry_count)
    );

    pixel_pll_supervisor #(
        .NUM_MODES(3), .DEFAULT_MODE(1), .RST_CYCLES(RST_C),
        .LOCK_STABLE_CYCLES(STAB_C), .LOCK_TIMEOUT_CYCLES(TMO_C), .MAX_RETRIES(MAXR)
    ) u_dut3 (
        .refclk(refclk), .rst(rst), .locked(locked), .mode_sel(mode_sel3), .mode_req(mode_req3),
        .pll_rst(pll_rst3), .pll_mode(pll_mode3), .pixel_rst(pixel_rst3), .ready(ready3),
        .fault(fault3), .mode_err(mode_err3), .retry_count(retry_count3)
    );

    always #5 refclk = ~refclk;

    // Reference model: which phase we are in, how long we have been there, and the lock history.
    int m_phase, m_elapsed, m_retries, m_mode;
    bit m_err, m_s1, m_s2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_RST; m_elapsed = 0; m_retries = 0; m_mode = 1;
        m_err = 0; m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_step(input bit lk, input bit req, input int sel);
        int  nxt;
        bit  lock_seen, flush, accepted;
        lock_seen = m_s2;
        flush     = (m_phase == P_RST) || (m_phase == P_FLT);
        accepted  = req && (sel < NMODES);
        nxt       = m_phase;
        m_err     = req && !accepted;
        if (accepted) begin
            m_mode = sel; m_retries = 0; nxt = P_RST;
        end else begin
            case (m_phase)
                P_RST:  if (m_elapsed + 1 >= RST_C) nxt = P_WAIT;
                P_WAIT: if (lock_seen) nxt = P_STAB;
                        else if (m_elapsed + 1 >= TMO_C) begin
                            if (m_retries < MAXR) begin m_retries++; nxt = P_RST; end
                            else nxt = P_FLT;
                        end
                P_STAB: if (!lock_seen) nxt = P_WAIT;
                        else if (m_elapsed + 1 >= STAB_C) nxt = P_RUN;
                P_RUN:  if (!lock_seen) begin
`ifdef PLL_SUP_AUTO_RELOCK_EN
                            nxt = P_RST; m_retries = 0;
`else
                            nxt = P_FLT;
`endif
                        end
                default: ;
            endcase
        end
        if (flush) begin m_s1 = 0; m_s2 = 0; end
        else begin m_s2 = m_s1; m_s1 = lk; end
        m_elapsed = (accepted || nxt != m_phase) ? 0 : m_elapsed + 1;
        m_phase   = nxt;
    endtask

    task automatic compare_all();
        check_eq("pll_rst",     pll_rst,     (m_phase == P_RST) || (m_phase == P_FLT));
        check_eq("pixel_rst",   pixel_rst,   m_phase != P_RUN);
        check_eq("ready",       ready,       m_phase == P_RUN);
        check_eq("fault",       fault,       m_phase == P_FLT);
        check_eq("mode_err",    mode_err,    m_err);
        check_eq("pll_mode",    pll_mode,    m_mode);
        check_eq("retry_count", retry_count, m_retries);
    endtask

    task automatic tick();
        bit lk, rq;
        int sl;
        lk = locked; rq = mode_req; sl = int'(mode_sel);
        @(posedge refclk);
        if (rst) model_reset();
        else     model_step(lk, rq, sl);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n, falls, rises;
        int seen [2];
        bit prev;
        model_reset();

        // Reset and clean bring-up with lock already present
        for (int i = 0; i < 3; i++) tick();
        check_eq("rst_pll_mode", pll_mode, 1);
        rst = 1'b0;
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
            if (n == 3) check_eq("pll_rst_held", pll_rst, 1);
            if (n == 4) check_eq("pll_rst_release", pll_rst, 0);
        end
        check_eq("bringup_cycles", n, RST_C + 2 + 1 + STAB_C);
        check_eq("bringup_pixel_rst", pixel_rst, 0);
        check_eq("dut3_ready", ready3, 1);

        // Out-of-range mode on the 3-mode instance
        mode_sel3 = 2'd3; mode_req3 = 1'b1;
        tick();
        mode_req3 = 1'b0;
        check_eq("bad_mode_err", mode_err3, 1);
        check_eq("bad_mode_ready", ready3, 1);
        tick();
        check_eq("bad_mode_err_pulse", mode_err3, 0);
        check_eq("bad_mode_ready2", ready3, 1);
        check_eq("bad_mode_keep", pll_mode3, 1);

        // Lock loss in RUN
        locked = 1'b0;
        tick(); check_eq("loss_ready_e1", ready, 1);
        tick(); check_eq("loss_ready_e2", ready, 1);
        tick(); check_eq("loss_ready_e3", ready, 0);
        check_eq("loss_pixel_rst", pixel_rst, 1);
`ifdef PLL_SUP_AUTO_RELOCK_EN
        check_eq("loss_relock_fault", fault, 0);
        check_eq("loss_relock_pll_rst", pll_rst, 1);
`else
        check_eq("loss_fault", fault, 1);
        for (int i = 0; i < 20; i++) tick();
        check_eq("loss_fault_sticky", fault, 1);
`endif

        // Timeout with retries
        do_reset();
        falls = 0; rises = 0; prev = pll_rst; n = 0;
        while (!fault && n < 300) begin
            tick();
            n++;
            if (prev && !pll_rst) falls++;
            if (!prev && pll_rst && !fault && rises < 2) begin
                seen[rises] = int'(retry_count);
                rises++;
            end
            prev = pll_rst;
        end
        check_eq("timeout_fault", fault, 1);
        check_eq("timeout_pulses", falls, 3);
        check_eq("timeout_retries", rises, 2);
        check_eq("retry_step1", seen[0], 1);
        check_eq("retry_step2", seen[1], 2);
        for (int i = 0; i < 10; i++) tick();
        check_eq("fault_pll_rst_held", pll_rst, 1);

        // Mode recovery from FAULT
        mode_sel = 1'b0; mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        check_eq("recover_fault", fault, 0);
        check_eq("recover_mode", pll_mode, 0);
        check_eq("recover_pll_rst", pll_rst, 1);
        check_eq("recover_retry", retry_count, 0);
        locked = 1'b1;
        n = 0;
        while (!ready && n < 40) begin tick(); n++; end
        check_eq("recover_ready", ready, 1);

        // Async reset in the middle of STABLE
        mode_sel = 1'b0; mode_req = 1'b1;
        tick();
        mode_req = 1'b0;
        n = 0;
        while (m_phase != P_STAB && n < 40) begin tick(); n++; end
        tick();
        #2 rst = 1'b1;
        #1;
        check_eq("async_pll_rst", pll_rst, 1);
        check_eq("async_pixel_rst", pixel_rst, 1);
        check_eq("async_ready", ready, 0);
        check_eq("async_fault", fault, 0);
        check_eq("async_retry", retry_count, 0);
        check_eq("async_mode", pll_mode, 1);
        model_reset();
        tick();
        rst = 1'b0;

        // Glitchy lock during STABLE
        n = 0;
        while (!(m_phase == P_STAB && m_elapsed == 3) && n < 40) begin tick(); n++; end
        locked = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        locked = 1'b1;
        n = 0;
        while (!ready && n < 40) begin tick(); n++; end
        check_eq("glitch_recover_cycles", n, 2 + 1 + STAB_C);

        // Randomised lock behaviour and mode requests
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) locked = ~locked;
            mode_req = ($urandom_range(0, 99) == 0);
            mode_sel = 1'($urandom_range(0, 1));
            tick();
        end
        mode_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
